// File: rtl/io_bus_master.sv
// epRISC I/O register bus initiator: one CPU request at a time, fixed-length bus cycle, IRQ merge.
// Optional local IRQ mask register at the top device index when IOBUS_IRQ_MASK_EN is defined.
module io_bus_master #(
    parameter int unsigned DEV_COUNT   = 4,
    parameter int unsigned DEV_SEL_W   = 2,
    parameter int unsigned REG_ADDR_W  = 2,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iReqValid,
    output logic                  oReqReady,
    input  logic                  iReqWrite,
    input  logic [DEV_SEL_W-1:0]  iReqDevice,
    input  logic [REG_ADDR_W-1:0] iReqAddress,
    input  logic [DATA_W-1:0]     iReqData,
    output logic                  oRspValid,
    input  logic                  iRspReady,
    output logic [DATA_W-1:0]     oRspData,
    output logic                  oRspError,
    output logic [REG_ADDR_W-1:0] oAddress,
    output logic [DATA_W-1:0]     oData,
    input  logic [DATA_W-1:0]     iData,
    output logic                  oWrite,
    output logic [DEV_COUNT-1:0]  oEnable,
    input  logic [DEV_COUNT-1:0]  iIrq,
    output logic                  oIrq,
    output logic [3:0]            oIrqVector
);

    typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

    state_e                  state;
    logic                    req_write;
    logic [DEV_SEL_W-1:0]    req_dev;
    logic [REG_ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]       req_data;
    logic [3:0]              wait_cnt;

    logic                    dev_no_bus;
    logic [DEV_COUNT-1:0]    dev_onehot;
    logic                    local_err;
    logic [DATA_W-1:0]       local_data;
    logic [DEV_COUNT-1:0]    irq_masked;
    logic [3:0]              irq_vec;

`ifdef IOBUS_IRQ_MASK_EN
    localparam logic [DEV_SEL_W-1:0] MaskDev = '1;

    logic [DEV_COUNT-1:0] irq_mask;
    logic                 mask_hit;

    // The mask slot wins over the range check, so it is never forwarded to the bus.
    assign dev_no_bus = (iReqDevice == MaskDev) || (32'(iReqDevice) >= DEV_COUNT);
    assign mask_hit   = (req_dev == MaskDev) && (req_addr == '0);
    assign irq_masked = iIrq & irq_mask;
`else
    assign dev_no_bus = 32'(iReqDevice) >= DEV_COUNT;
    assign irq_masked = iIrq;
`endif

    assign dev_onehot = DEV_COUNT'(1) << req_dev;

    // Response for requests that never reach the bus (range errors and mask accesses).
    always_comb begin
        local_err  = 1'b1;
        local_data = '0;
`ifdef IOBUS_IRQ_MASK_EN
        if (mask_hit) begin
            local_err  = 1'b0;
            local_data = req_write ? '0 : DATA_W'(irq_mask);
        end
`endif
    end

    always_comb begin
        irq_vec = '0;
        for (int i = int'(DEV_COUNT) - 1; i >= 0; i--) begin
            if (irq_masked[i]) begin
                irq_vec = 4'(i);
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state      <= StIdle;
            req_write  <= 1'b0;
            req_dev    <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            wait_cnt   <= '0;
            oReqReady  <= 1'b1;
            oRspValid  <= 1'b0;
            oRspData   <= '0;
            oRspError  <= 1'b0;
            oAddress   <= '0;
            oData      <= '0;
            oWrite     <= 1'b0;
            oEnable    <= '0;
            oIrq       <= 1'b0;
            oIrqVector <= '0;
`ifdef IOBUS_IRQ_MASK_EN
            irq_mask   <= '1;
`endif
        end else begin
            oIrq       <= |irq_masked;
            oIrqVector <= irq_vec;

            unique case (state)
                StIdle: begin
                    if (iReqValid) begin
                        req_write <= iReqWrite;
                        req_dev   <= iReqDevice;
                        req_addr  <= iReqAddress;
                        req_data  <= iReqData;
                        oReqReady <= 1'b0;
                        if (dev_no_bus) begin
                            state <= StRespond;
                        end else begin
                            state    <= StAccess;
                            wait_cnt <= 4'(WAIT_STATES);
                        end
                    end
                end

                StAccess: begin
                    // First ACCESS cycle launches the registered bus outputs.
                    if (oEnable == '0) begin
                        oEnable  <= dev_onehot;
                        oWrite   <= req_write;
                        oAddress <= req_addr;
                        oData    <= req_data;
                    end else if (wait_cnt == '0) begin
                        oEnable   <= '0;
                        oWrite    <= 1'b0;
                        oAddress  <= '0;
                        oData     <= '0;
                        oRspValid <= 1'b1;
                        oRspError <= 1'b0;
                        oRspData  <= req_write ? '0 : iData;
                        state     <= StRespond;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                StRespond: begin
                    if (!oRspValid) begin
                        oRspValid <= 1'b1;
                        oRspError <= local_err;
                        oRspData  <= local_data;
`ifdef IOBUS_IRQ_MASK_EN
                        if (mask_hit && req_write) begin
                            irq_mask <= req_data[DEV_COUNT-1:0];
                        end
`endif
                    end else if (iRspReady) begin
                        oRspValid <= 1'b0;
                        oRspError <= 1'b0;
                        oReqReady <= 1'b1;
                        state     <= StIdle;
                    end
                end

                default: begin
                    state     <= StIdle;
                    oReqReady <= 1'b1;
                end
            endcase
        end
    end

    a_enable_onehot: assert property (@(posedge iClock) disable iff (!iReset)
        $onehot0(oEnable));
    a_write_needs_enable: assert property (@(posedge iClock) disable iff (!iReset)
        oWrite |-> (oEnable != '0));

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
- Initiator side of the epRISC I/O register bus: the master that drives peripheral slaves such as the GPIO controller.
- Accepts single register read/write requests from the CPU over a valid/ready handshake.
- Runs a fixed-length bus cycle on the shared address/data/write lines, asserting the one-hot enable of the selected device, and returns read data or a write acknowledge over a second valid/ready handshake.
- Also aggregates the peripherals' interrupt lines toward the CPU.

Parameters:
- DEV_COUNT, 4: number of attached slaves (1..16); width of oEnable and iIrq.
- DEV_SEL_W, 2: width of iReqDevice; must satisfy 2^DEV_SEL_W >= DEV_COUNT.
- REG_ADDR_W, 2: register address width driven on oAddress.
- DATA_W, 16: bus data width.
- WAIT_STATES, 1: extra bus cycles per access (0..15); enable is held for WAIT_STATES+1 cycles.

Ports:
- iClock, input, 1: system clock; all state changes on the rising edge.
- iReset, input, 1: reset, asynchronous, active-low.
- iReqValid, input, 1: CPU request valid.
- oReqReady, output, 1: master can accept a request.
- iReqWrite, input, 1: 1 = write, 0 = read.
- iReqDevice, input, DEV_SEL_W: target device index.
- iReqAddress, input, REG_ADDR_W: target register.
- iReqData, input, DATA_W: write data.
- oRspValid, output, 1: response valid.
- iRspReady, input, 1: CPU accepts the response.
- oRspData, output, DATA_W: read data (0 for writes and errors).
- oRspError, output, 1: device index out of range.
- oAddress, output, REG_ADDR_W: bus register address.
- oData, output, DATA_W: bus write data.
- iData, input, DATA_W: bus read data (shared; slaves tri-state when not selected).
- oWrite, output, 1: bus write strobe.
- oEnable, output, DEV_COUNT: one-hot device select.
- iIrq, input, DEV_COUNT: per-device interrupt lines, active-high, level.
- oIrq, output, 1: interrupt to CPU.
- oIrqVector, output, 4: index of the serviced interrupt source.

Behaviour:
- Reset (iReset low, asynchronous): FSM to IDLE. All outputs 0 except oReqReady = 1. Wait counter cleared. Mask register all-ones (feature enabled). Applies immediately, including mid-access: oEnable and oWrite drop without waiting for a clock edge. A partially completed response is discarded.
- FSM states: IDLE, ACCESS, RESPOND.
- IDLE:
  - oReqReady = 1.
  - On iReqValid, latch write, device, address and data.
  - If device >= DEV_COUNT, go to RESPOND with oRspError = 1 and oRspData = 0. No bus activity.
  - Otherwise go to ACCESS with counter = WAIT_STATES.
- ACCESS:
  - oReqReady = 0.
  - oAddress and oData hold the latched values; oWrite = latched write flag; oEnable = one-hot of the latched device.
  - Outputs are registered, so they are first valid in the cycle after acceptance.
  - Counter decrements each cycle. When the counter is 0, go to RESPOND at the next edge; on that same edge capture iData into oRspData for a read, or 0 for a write.
  - Enable is therefore high for exactly WAIT_STATES+1 cycles.
- RESPOND:
  - Bus outputs all 0: oEnable = 0, oWrite = 0, oAddress = 0, oData = 0.
  - oRspValid = 1; oRspData and oRspError are stable until iRspReady.
  - On iRspReady, return to IDLE. oRspValid and oRspError clear.
- Latency: request accepted at edge N; response valid from edge N+WAIT_STATES+2. Error responses are valid from edge N+1. A new request can be accepted one cycle after the response handshake.
- Requests presented while busy are ignored (not latched). The CPU must hold them until oReqReady.
- oEnable is never multi-hot. oWrite is never high while oEnable = 0.
- Interrupts:
  - oIrq = OR of (iIrq AND mask), registered.
  - oIrqVector = lowest-index active masked source, registered; 0 when none.
  - Interrupts are never cleared by the master. Slaves clear their own lines on access.

Optional Feature:
- Macro: IOBUS_IRQ_MASK_EN.
- Defined:
  - Device index 2^DEV_SEL_W−1 is reserved as a local mask register and is never forwarded to the bus. This requires DEV_COUNT < 2^DEV_SEL_W; if DEV_COUNT equals it, the highest device becomes unreachable.
  - Access addresses the mask only when iReqAddress = 0; any other address returns oRspError = 1.
  - A write loads the mask from the low DEV_COUNT data bits. A read returns the mask zero-extended.
  - Mask-register accesses behave as error accesses (response at N+1, no bus cycle), but with oRspError = 0.
- Undefined: no mask register (mask is effectively all-ones), and index 2^DEV_SEL_W−1 follows the normal range check.

Test Plan:
- Reset low for 3 cycles, then high → oReqReady = 1, oEnable = 0, oRspValid = 0, oIrq = 0.
- WAIT_STATES = 1; write device 1, address 0, data 16'h00FF → oEnable = 4'b0010, oWrite = 1, oData = 16'h00FF for exactly 2 cycles; oRspValid at edge N+3 with data 0.
- Read device 2, address 2, slave drives 16'hA5C3 → oRspValid with oRspData = 16'hA5C3. Hold iRspReady low for 5 cycles → data stable and no new request accepted.
- DEV_COUNT = 3, request device 3 (feature off) → oRspError = 1 at N+1, oEnable stays 0.
- iIrq = 4'b1010 → oIrq = 1, oIrqVector = 1. With IOBUS_IRQ_MASK_EN, write mask 4'b1000 → oIrqVector = 3; write mask 0 → oIrq = 0.
- Assert iReset low during the second ACCESS cycle → oEnable and oWrite fall asynchronously; after release, the FSM is in IDLE with oRspValid = 0.
